// File: rtl/cylon_n.sv
// cylon_n: parametrised LED pattern generator.
// A prescaler carry advances a position/direction/phase state. Four display
// modes are supported: bounce, chase, two-eye and blink. The pattern is
// computed from that state and registered into q. A mode change restarts the
// pattern from position 0 but leaves the prescaler running.
module cylon_n #(
  parameter int WIDTH = 12,   // LEDs driven, 2..32
  parameter int MXPRE = 21    // prescaler width, >= 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       rate,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             step
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_CHASE  = 2'd1,
    M_TWOEYE = 2'd2,
    M_BLINK  = 2'd3
  } mode_e;

  logic [MXPRE-1:0] pre_q, pre_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             phase_q, phase_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step_q, step_d;

  logic [MXPRE:0]   sum;
  logic             tick;
  logic             mode_chg;

  function automatic logic [WIDTH-1:0] onehot(input logic [PW-1:0] p);
    onehot = WIDTH'(1) << p;
  endfunction

  // Next-state: prescaler add with carry, position/phase advance, pattern decode
  always_comb begin
    pre_d   = pre_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    mode_d  = mode_e'(mode);
    tick    = 1'b0;
    q_d     = '0;

    // The carry out of a full-width add is the tick: no compare, so no rate
    // value can ever skip past a terminal count.
    sum = {1'b0, pre_q} + {{(MXPRE - 1){1'b0}}, rate} + (MXPRE + 1)'(1);

    if (!pause) begin
      pre_d = sum[MXPRE-1:0];
      tick  = sum[MXPRE];
    end

    mode_chg = (mode_e'(mode) != mode_q);

    if (mode_chg) begin
      // Restart the new mode from its first pattern; a coincident tick is dropped.
      pos_d   = '0;
      dir_d   = DIR_UP;
      phase_d = 1'b0;
    end else if (tick) begin
      case (mode_q)
        M_CHASE: begin
          dir_d = DIR_UP;
          pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
        end
        M_BLINK: begin
          phase_d = ~phase_q;
        end
        default: begin
          // Bounce / two-eye: turn around at the ends without dwelling there.
          if (dir_q == DIR_UP) begin
            if (pos_q == LAST) begin
              pos_d = LAST - 1'b1;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PW'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
      endcase
    end

    step_d = tick & ~mode_chg;

    case (mode_q)
      M_TWOEYE: q_d = onehot(pos_q) | onehot(LAST - pos_q);
      M_BLINK:  q_d = {WIDTH{phase_q}};
      default:  q_d = onehot(pos_q);
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      mode_q  <= M_BOUNCE;
      q_q     <= '0;
      step_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      step_q  <= step_d;
    end
  end

  assign q    = q_q;
  assign step = step_q;

endmodule

// File: tb/tb_cylon_n.sv
// Directed bench for cylon_n: a WIDTH=4 and a WIDTH=5 instance share all inputs.
module tb_cylon_n;

  logic       clock;
  logic       reset_n;
  logic [1:0] rate;
  logic [1:0] mode;
  logic       pause;
  logic [3:0] q4;
  logic       step4;
  logic [4:0] q5;
  logic       step5;

  int tests;
  int fails;

  cylon_n #(.WIDTH(4), .MXPRE(2)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .rate    (rate),
    .mode    (mode),
    .pause   (pause),
    .q       (q4),
    .step    (step4)
  );

  cylon_n #(.WIDTH(5), .MXPRE(2)) dut5 (
    .clock   (clock),
    .reset_n (reset_n),
    .rate    (rate),
    .mode    (mode),
    .pause   (pause),
    .q       (q5),
    .step    (step5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_bounce [7];
  logic [3:0] exp_r1     [4];
  logic [3:0] exp_r3     [4];
  logic [3:0] exp_chase  [4];

  initial begin
    tests = 0;
    fails = 0;
    exp_bounce = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    exp_r1     = '{4'b0100, 4'b1000, 4'b0100, 4'b0010};
    exp_r3     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_chase  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_n = 1'b0;
    rate    = 2'd0;
    mode    = 2'd0;
    pause   = 1'b0;

    // Reset state
    clk_n(3);
    chk("reset_q4", q4, 4'b0000);
    chk("reset_step4", step4, 1'b0);
    chk("reset_q5", q5, 5'b00000);

    // Bounce, rate 0: tick every 4 clocks
    reset_n = 1'b1;
    clk_n(1);
    chk("bounce_first_q", q4, 4'b0001);
    chk("bounce_first_step", step4, 1'b0);
    clk_n(2);
    chk("bounce_hold_q", q4, 4'b0001);
    chk("bounce_hold_step", step4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      clk_n(1);
      chk($sformatf("bounce_step_%0d", i), step4, 1'b1);
      clk_n(1);
      chk($sformatf("bounce_q_%0d", i), q4, exp_bounce[i]);
      chk($sformatf("bounce_stepoff_%0d", i), step4, 1'b0);
      if (i < 6) clk_n(2);
    end

    // Rate 1: advance every 2 clocks, no missed carries
    rate = 2'd1;
    clk_n(1);
    for (int i = 0; i < 4; i++) begin
      clk_n(1);
      chk($sformatf("rate1_step_%0d", i), step4, 1'b1);
      clk_n(1);
      chk($sformatf("rate1_q_%0d", i), q4, exp_r1[i]);
      chk($sformatf("rate1_stepoff_%0d", i), step4, 1'b0);
    end

    // Rate 3: advance every clock
    rate = 2'd3;
    clk_n(1);
    chk("rate3_step_first", step4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      clk_n(1);
      chk($sformatf("rate3_q_%0d", i), q4, exp_r3[i]);
      chk($sformatf("rate3_step_%0d", i), step4, 1'b1);
    end

    // Asynchronous reset mid-bounce while travelling down
    rate    = 2'd0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_q", q4, 4'b0000);
    chk("async_reset_step", step4, 1'b0);
    clk_n(2);
    chk("async_reset_hold_q", q4, 4'b0000);
    reset_n = 1'b1;
    clk_n(1);
    chk("restart_q0", q4, 4'b0001);
    clk_n(4);
    chk("restart_q1_dir_up", q4, 4'b0010);
    clk_n(4);
    chk("restart_q2", q4, 4'b0100);
    clk_n(3);
    chk("restart_step_to_pos3", step4, 1'b1);
    clk_n(1);
    chk("restart_q3", q4, 4'b1000);

    // Mode change to chase on the cycle a tick would occur
    clk_n(2);
    mode = 2'd1;
    clk_n(1);
    chk("modechg_step_suppressed", step4, 1'b0);
    chk("modechg_q_old", q4, 4'b1000);
    clk_n(1);
    chk("modechg_q_new", q4, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      clk_n(3);
      chk($sformatf("chase_step_%0d", i), step4, 1'b1);
      clk_n(1);
      chk($sformatf("chase_q_%0d", i), q4, exp_chase[i]);
    end

    // Two-eye
    mode = 2'd2;
    clk_n(1);
    chk("twoeye_chg_step", step4, 1'b0);
    clk_n(1);
    chk("twoeye_q5_0", q5, 5'b10001);
    chk("twoeye_q4_0", q4, 4'b1001);
    clk_n(1);
    chk("twoeye_step_0", step5, 1'b1);
    clk_n(1);
    chk("twoeye_q5_1", q5, 5'b01010);
    chk("twoeye_q4_1", q4, 4'b0110);
    clk_n(4);
    chk("twoeye_q5_2", q5, 5'b00100);
    chk("twoeye_q4_2", q4, 4'b0110);
    clk_n(4);
    chk("twoeye_q5_3", q5, 5'b01010);
    chk("twoeye_q4_3", q4, 4'b1001);
    clk_n(4);
    chk("twoeye_q5_4", q5, 5'b10001);
    chk("twoeye_q4_4", q4, 4'b0110);

    // Blink
    mode = 2'd3;
    clk_n(2);
    chk("blink_off_0", q4, 4'b0000);
    chk("blink_off_0_w5", q5, 5'b00000);
    clk_n(2);
    chk("blink_on_0", q4, 4'b1111);
    chk("blink_on_0_w5", q5, 5'b11111);
    clk_n(3);
    chk("blink_on_hold", q4, 4'b1111);
    clk_n(1);
    chk("blink_off_1", q4, 4'b0000);
    clk_n(4);
    chk("blink_on_1", q4, 4'b1111);

    // Pause: everything frozen, then resumes from the frozen prescaler value
    pause = 1'b1;
    for (int i = 0; i < 22; i++) begin
      clk_n(1);
      chk($sformatf("pause_q_%0d", i), q4, 4'b1111);
      chk($sformatf("pause_step_%0d", i), step4, 1'b0);
    end
    pause = 1'b0;
    clk_n(2);
    chk("resume_no_early_step", step4, 1'b0);
    clk_n(1);
    chk("resume_step", step4, 1'b1);
    chk("resume_q_hold", q4, 4'b1111);
    clk_n(1);
    chk("resume_q", q4, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cylon_n.md
Name: cylon_n

Overview:
- Parametrised LED pattern generator; successor to the fixed 4-bit single-eye cylon.
- Drives a WIDTH-bit front-panel/optohybrid LED bank from the system clock.
- Prescaled step rate, four selectable display modes (bounce, chase, two-eye, blink) and a pause input.
- Sits beside the board status logic; purely a visual indicator, with no handshakes to other blocks.

Parameters:
- WIDTH, 12, number of LEDs driven; legal range 2..32.
- MXPRE, 21, prescaler width; step period is 2^MXPRE/(rate+1) clocks. Benches use MXPRE=2.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rate  input  2  step speed; prescaler increment = rate+1.
- mode  input  2  0=bounce, 1=chase, 2=two-eye, 3=blink.
- pause  input  1  high freezes prescaler and pattern; q holds.
- q  output  WIDTH  registered LED pattern.
- step  output  1  registered one-cycle pulse, high the cycle after each pattern advance.

Behaviour:
- Reset (reset_n low, async):
  - prescaler=0, pos=0, dir=up, phase=0, mode_q=0.
  - Outputs q=0 and step=0 are held while reset_n is low.
  - Reset mid-sequence aborts immediately. After release, the first clock loads q from pos=0.
- Prescaler:
  - Each clock with pause=0: {carry, prescaler} <= prescaler + rate + 1, computed at MXPRE+1 bits.
  - tick = carry.
  - Any rate value always produces ticks; there is no equality compare that can be skipped.
  - With pause=1: prescaler holds and tick=0.
- Position state, advanced only on tick:
  - bounce and two-eye: at dir=up, pos<WIDTH-1 gives pos+1. At pos=WIDTH-1, pos becomes WIDTH-2 and dir becomes down. Mirror image at pos=0 going down.
  - Bounce period is 2*(WIDTH-1) ticks. End LEDs are lit for one step only; there is no double-dwell.
  - chase: pos+1, wrapping WIDTH-1 to 0. dir is forced up.
  - blink: phase toggles; pos is unchanged.
- Pattern, combinational from state and registered into q every clock (one-cycle latency from state to q):
  - bounce and chase: q = one-hot(pos).
  - two-eye: q = one-hot(pos) | one-hot(WIDTH-1-pos). The two eyes cross at the centre. For odd WIDTH a single LED is lit at the centre.
  - blink: q = all ones when phase=1, all zeros when phase=0.
- Mode change:
  - mode_q registers mode every clock.
  - When mode != mode_q: pos<=0, dir<=up, phase<=0, and a tick on that same cycle is discarded. The prescaler is not reset.
  - The new pattern appears on q two clocks after the mode input changes.
- step <= tick, gated to 0 on a mode-change cycle.
- Pause has priority over tick. Mode-change reset still applies while paused.
- rate may change at any time. It takes effect on the next add; no glitch handling is required.

Test Plan:
- WIDTH=4, MXPRE=2, rate=0, mode=0, release reset:
  - q=0001 one clock after release.
  - tick every 4 clocks.
  - q sequence 0001,0010,0100,1000,0100,0010,0001,0010 (period 6 steps).
  - step pulses once per advance.
- Same setup, rate=1 then rate=3:
  - advances every 2 clocks, then every clock.
  - No missed ticks with rate=1 (guards the old equality-compare bug).
- mode=1, WIDTH=4:
  - q 0001,0010,0100,1000,0001 (wrap).
- mode=2, WIDTH=5:
  - q 10001,01010,00100,01010,10001.
- mode=3, rate=0:
  - q alternates 0000/1111 every 4 clocks.
- Directed boundary checks:
  - Switch mode mid-sequence at pos=3: q restarts at that mode's pos=0 pattern two clocks later, and step is suppressed on that cycle.
  - pause=1 for 20 clocks: q and prescaler frozen, step=0.
  - Assert reset_n low mid-bounce at dir=down: q=0 asynchronously; sequence restarts at 0001 with dir=up.
